// File: rtl/mem_access_initiator.sv
// -----------------------------------------------------------------------------
// mem_access_initiator
//
// Processor-side master for the data-memory access protocol. Requests from the
// pipeline are accepted on a valid/ready port and queued in a small FIFO.
// Each request is issued to memory with registered command outputs that stay
// stable until access_done. Every accepted request produces exactly one
// response, in order, with read data, an error flag and the measured latency.
// Misaligned requests are never issued; they return an error response instead.
//
// Optional feature macro: MEM_INIT_STATS_EN
//   When defined, adds the statistics outputs stat_accesses, stat_busy_cycles
//   and stat_max_latency. When undefined these ports do not exist.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   req_valid/ready   request handshake (ready = FIFO not full)
//   req_addr          byte address
//   req_wdata         write data
//   req_bytemask      write byte enables
//   req_write         1 = write, 0 = read
//   rsp_valid         one-cycle response pulse
//   rsp_write         response belongs to a write
//   rsp_err           request was misaligned and not issued
//   rsp_rdata         read data (0 for writes and errors)
//   rsp_latency       cycles start_access was high, saturating; 0 on error
//   address, data_in, bytemask, write, start_access   command to memory
//   access_done, data_out                             reply from memory
// -----------------------------------------------------------------------------
module mem_access_initiator #(
    parameter int ADDR_WIDTH  = 20,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [63:0]           req_wdata,
    input  logic [7:0]            req_bytemask,
    input  logic                  req_write,
    output logic                  rsp_valid,
    output logic                  rsp_write,
    output logic                  rsp_err,
    output logic [63:0]           rsp_rdata,
    output logic [15:0]           rsp_latency,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [63:0]           data_in,
    output logic [7:0]            bytemask,
    output logic                  write,
    output logic                  start_access,
    input  logic                  access_done,
    input  logic [63:0]           data_out
`ifdef MEM_INIT_STATS_EN
    ,
    output logic [31:0]           stat_accesses,
    output logic [31:0]           stat_busy_cycles,
    output logic [15:0]           stat_max_latency
`endif
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    // Saturating latency increment: the counter sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : (v + 16'd1);
    endfunction

    // -------------------------------------------------------------------------
    // Request FIFO
    // -------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] r_q_addr  [QUEUE_DEPTH];
    logic [63:0]           r_q_wdata [QUEUE_DEPTH];
    logic [7:0]            r_q_mask  [QUEUE_DEPTH];
    logic                  r_q_write [QUEUE_DEPTH];
    logic                  r_q_err   [QUEUE_DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_head_valid;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [63:0]           w_head_wdata;
    logic [7:0]            w_head_mask;
    logic                  w_head_write;
    logic                  w_head_err;

    // Ready depends only on registered occupancy, so a full FIFO never sees
    // a push and a pop in the same cycle.
    assign req_ready    = (r_count != CNT_W'(QUEUE_DEPTH));
    assign w_push       = req_valid && req_ready;
    assign w_head_valid = (r_count != '0);
    assign w_head_addr  = r_q_addr[r_rd_ptr];
    assign w_head_wdata = r_q_wdata[r_rd_ptr];
    assign w_head_mask  = r_q_mask[r_rd_ptr];
    assign w_head_write = r_q_write[r_rd_ptr];
    assign w_head_err   = r_q_err[r_rd_ptr];

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_addr[r_wr_ptr]  <= req_addr;
            r_q_wdata[r_wr_ptr] <= req_wdata;
            r_q_mask[r_wr_ptr]  <= req_bytemask;
            r_q_write[r_wr_ptr] <= req_write;
            r_q_err[r_wr_ptr]   <= (req_addr[2:0] != 3'b000);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Issue FSM
    // -------------------------------------------------------------------------
    state_t r_state;
    state_t w_next_state;

    logic                  r_start_access;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [63:0]           r_data_in;
    logic [7:0]            r_bytemask;
    logic                  r_write;
    logic [15:0]           r_lat;

    logic        r_rsp_valid;
    logic        r_rsp_write;
    logic        r_rsp_err;
    logic [63:0] r_rsp_rdata;
    logic [15:0] r_rsp_latency;

    logic w_load;
    logic w_start_next;
    logic w_err_ev;
    logic w_done_ev;

    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_load       = 1'b0;
        w_start_next = r_start_access;
        w_err_ev     = 1'b0;
        w_done_ev    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_head_valid) begin
                    w_pop = 1'b1;
                    if (w_head_err) begin
                        // Misaligned entries retire straight from the head,
                        // one per cycle, without touching the memory port.
                        w_err_ev = 1'b1;
                    end else begin
                        w_load       = 1'b1;
                        w_start_next = 1'b1;
                        w_next_state = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (access_done) begin
                    w_done_ev = 1'b1;
                    if (w_head_valid && !w_head_err) begin
                        // Back-to-back: reload on the completing edge so
                        // start_access never drops between accesses.
                        w_pop        = 1'b1;
                        w_load       = 1'b1;
                        w_start_next = 1'b1;
                    end else begin
                        w_start_next = 1'b0;
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_start_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_start_access <= 1'b0;
            r_address      <= '0;
            r_data_in      <= '0;
            r_bytemask     <= '0;
            r_write        <= 1'b0;
            r_lat          <= '0;
        end else begin
            r_state        <= w_next_state;
            r_start_access <= w_start_next;
            if (w_load) begin
                r_address  <= w_head_addr;
                r_data_in  <= w_head_wdata;
                r_bytemask <= w_head_mask;
                r_write    <= w_head_write;
                // The loading edge starts the first high cycle of start_access.
                r_lat      <= 16'd1;
            end else if (r_state == S_ISSUE && !access_done) begin
                r_lat      <= sat_inc16(r_lat);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_write   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_latency <= '0;
        end else begin
            r_rsp_valid   <= w_err_ev || w_done_ev;
            r_rsp_write   <= 1'b0;
            r_rsp_err     <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_latency <= '0;
            if (w_err_ev) begin
                r_rsp_write <= w_head_write;
                r_rsp_err   <= 1'b1;
            end else if (w_done_ev) begin
                // r_write still describes the completing access even when a
                // new request is loaded on this same edge.
                r_rsp_write   <= r_write;
                r_rsp_rdata   <= r_write ? 64'd0 : data_out;
                r_rsp_latency <= r_lat;
            end
        end
    end

    assign start_access = r_start_access;
    assign address      = r_address;
    assign data_in      = r_data_in;
    assign bytemask     = r_bytemask;
    assign write        = r_write;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_write    = r_rsp_write;
    assign rsp_err      = r_rsp_err;
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_latency  = r_rsp_latency;

`ifdef MEM_INIT_STATS_EN
    // -------------------------------------------------------------------------
    // Access statistics
    // -------------------------------------------------------------------------
    logic [31:0] r_stat_accesses;
    logic [31:0] r_stat_busy_cycles;
    logic [15:0] r_stat_max_latency;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_accesses    <= '0;
            r_stat_busy_cycles <= '0;
            r_stat_max_latency <= '0;
        end else begin
            if (w_load) begin
                r_stat_accesses <= r_stat_accesses + 32'd1;
            end
            if (r_start_access) begin
                r_stat_busy_cycles <= r_stat_busy_cycles + 32'd1;
            end
            if (w_done_ev && (r_lat > r_stat_max_latency)) begin
                r_stat_max_latency <= r_lat;
            end
        end
    end

    assign stat_accesses    = r_stat_accesses;
    assign stat_busy_cycles = r_stat_busy_cycles;
    assign stat_max_latency = r_stat_max_latency;
`endif

endmodule

// File: doc/mem_access_initiator.md
# mem_access_initiator

Processor-side master for the data-memory access protocol (address / data_in / bytemask / write / start_access / access_done / data_out). It accepts requests from the pipeline through a valid/ready port and buffers them in a small FIFO. It issues each request to the memory hierarchy, holding every command field stable until access_done. It then returns one response per request with read data, an error flag and the measured access latency.

## Interface
Parameters:
- ADDR_WIDTH, 20: byte-address width; matches the memory's DMEM_ADDRESS_WIDTH.
- QUEUE_DEPTH, 4: request FIFO entries; power of 2, at least 2.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request offered.
- req_ready  out  1  FIFO not full.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  64  write data.
- req_bytemask  in  8  write byte enables.
- req_write  in  1  1 = write, 0 = read.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_write  out  1  response belongs to a write.
- rsp_err  out  1  request was misaligned and not issued.
- rsp_rdata  out  64  read data; 0 for writes and errors.
- rsp_latency  out  16  cycles start_access was high for this access, saturating at 16'hFFFF; 0 on error.
- address  out  ADDR_WIDTH  to memory.
- data_in  out  64  to memory.
- bytemask  out  8  to memory.
- write  out  1  to memory.
- start_access  out  1  to memory.
- access_done  in  1  from memory.
- data_out  in  64  from memory; valid only while access_done=1.

## Operation
- Request enqueue occurs when req_valid && req_ready.
  - A misaligned address (req_addr[2:0]!=0) is enqueued with an err tag.
  - No backpressure on responses.
- FSM states:
  - IDLE → ISSUE: head valid and not err. Load the head into the memory output registers, set start_access=1, pop, clear the latency counter to 1.
  - IDLE, head err: pop and emit rsp_valid=1, rsp_err=1, rsp_write=head.write. Stay in IDLE. One error per cycle.
  - ISSUE while access_done=0: hold all memory outputs unchanged; latency counter +1 (saturating).
  - ISSUE with access_done=1:
    - Emit a response. rsp_rdata=data_out on reads. rsp_latency=counter.
    - If the next head is valid and not err: load it in the same edge, keep start_access=1, stay in ISSUE (back-to-back).
    - Otherwise: start_access=0, go to IDLE.
- Memory outputs are registered. address, data_in, bytemask and write may change only on the edge that loads a new request.
- Responses are in request order. Exactly one response per accepted request.
- FIFO full: req_ready=0. Simultaneous push and pop when full is not allowed, because ready is computed from registered occupancy.
- Empty FIFO: no issue. start_access stays 0.

## Timing
- Reset values (next edge with reset=1):
  - FSM=IDLE, FIFO emptied.
  - start_access=0, rsp_valid=0, rsp_err=0, rsp_write=0.
  - rsp_rdata=0, rsp_latency=0.
  - address=0, data_in=0, bytemask=0, write=0.
  - req_ready=1 from the first cycle after reset.
- Reset mid-access drops the in-flight and queued requests without responses. The memory is reset by the same signal.
- Enqueue-to-start_access is 2 cycles minimum: FIFO write edge, then issue edge.
- Response timing:
  - rsp_valid asserts on the edge after access_done=1 is sampled.
  - rsp_latency equals the number of cycles start_access was high for this access: the memory access time plus 1.
- access_done=1 while start_access=0 is ignored.

## Configuration
- MEM_INIT_STATS_EN defined:
  - Adds outputs stat_accesses (32), stat_busy_cycles (32) and stat_max_latency (16), all reset to 0.
  - stat_accesses counts issued accesses, excluding errors.
  - stat_busy_cycles counts cycles with start_access=1.
  - stat_max_latency holds the largest rsp_latency.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Single read: memory model with 3-cycle access, data_out=64'hDEAD_BEEF_0000_0001 at addr 0x40. Required: start_access high 4 cycles; one rsp_valid; rsp_rdata matches; rsp_latency=4; rsp_write=0.
- Back-to-back: enqueue 4 reads (0x0, 0x8, 0x10, 0x18) in consecutive cycles. Required: req_ready stays 1 on all four enqueue cycles; start_access never drops between accesses; 4 in-order responses; command fields stable during every access.
- Full FIFO: memory stalls 50 cycles; offer 6 requests. Required: req_ready=0 after the issue pop plus 4 queued; no requests lost; 6 responses.
- Misaligned: write to 0x43 queued between reads at 0x0 and 0x8. Required: responses in order read/err/read; the err response has rsp_err=1, rsp_latency=0; address 0x43 never driven with start_access=1.
- Write: addr 0x100, bytemask 8'h0F, wdata 64'h1122334455667788; read back 0x100. Required: write response with rsp_rdata=0; read returns low 4 bytes 55667788 with upper bytes unchanged.
- Reset at cycle 2 of a stalled access with 2 queued. Required: next cycle start_access=0, req_ready=1, no rsp_valid; a subsequent read completes normally.
